// File: rtl/core_alu_wide.sv
// Multi-cycle WIDTH-bit ALU: nibble-serial binary/BCD add and subtract, single-cycle
// logic/pass/rotate, registered result and C/Z/V/N flags behind a start/busy/done handshake.
module core_alu_wide #(
    parameter int WIDTH = 16
) (
    input  logic             I_clock,
    input  logic             I_reset,
    input  logic             I_start,
    input  logic [3:0]       I_op,
    input  logic             I_decimal,
    input  logic [3:0]       I_flags_en,
    input  logic [WIDTH-1:0] I_lhs,
    input  logic [WIDTH-1:0] I_rhs,
    input  logic             I_carry,
    input  logic             I_overflow,
    input  logic             I_sign,
    input  logic             I_zero,
    output logic             O_busy,
    output logic             O_done,
    output logic [WIDTH-1:0] O_result,
    output logic             O_carry,
    output logic             O_overflow,
    output logic             O_sign,
    output logic             O_zero
);

    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

    localparam logic [3:0] OP_PASSR = 4'd1;
    localparam logic [3:0] OP_ADC   = 4'd2;
    localparam logic [3:0] OP_SBC   = 4'd3;
    localparam logic [3:0] OP_AND   = 4'd4;
    localparam logic [3:0] OP_OR    = 4'd5;
    localparam logic [3:0] OP_XOR   = 4'd6;
    localparam logic [3:0] OP_ROL   = 4'd7;
    localparam logic [3:0] OP_ROR   = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [3:0]       op_q, op_d;
    logic             dec_q, dec_d;
    logic [3:0]       fen_q, fen_d;
    logic [WIDTH-1:0] lhs_q, lhs_d;
    logic [WIDTH-1:0] rhs_q, rhs_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             cin_q, cin_d;
    logic             vin_q, vin_d;
    logic             nin_q, nin_d;
    logic             zin_q, zin_d;
    logic             c_q, c_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             flag_c_q, flag_c_d;
    logic             flag_v_q, flag_v_d;
    logic             flag_n_q, flag_n_d;
    logic             flag_z_q, flag_z_d;

    logic             is_sub_s;
    logic             is_arith_s;
    logic [IW+1:0]    base_s;
    logic [3:0]       nib_a_s;
    logic [3:0]       nib_b_s;
    logic [4:0]       bin_sum_s;
    logic [3:0]       dec_adj_s;
    logic [4:0]       dec_diff_s;
    logic [3:0]       nib_digit_s;
    logic             nib_cout_s;

    logic [WIDTH-1:0] logic_res_s;
    logic             logic_c_s;
    logic [WIDTH-1:0] arith_res_s;
    logic [WIDTH-1:0] fin_res_s;
    logic             fin_c_s;
    logic             fin_v_s;
    logic             rhs_eff_msb_s;
    logic             accept_s;
    logic             finish_s;

    // One nibble step of the serial adder/subtractor, binary or BCD.
    always_comb begin
        is_sub_s    = (op_q == OP_SBC);
        is_arith_s  = (op_q == OP_ADC) || is_sub_s;
        base_s      = {idx_q, 2'b00};
        nib_a_s     = lhs_q[base_s +: 4];
        nib_b_s     = is_sub_s ? ~rhs_q[base_s +: 4] : rhs_q[base_s +: 4];
        bin_sum_s   = {1'b0, nib_a_s} + {1'b0, nib_b_s} + {4'b0000, c_q};
        dec_adj_s   = bin_sum_s[3:0] + 4'd6;
        // Decimal subtract uses the true rhs digit and a borrow of (1 - c).
        dec_diff_s  = {1'b0, nib_a_s} - {1'b0, rhs_q[base_s +: 4]} - {4'b0000, ~c_q};
        nib_digit_s = bin_sum_s[3:0];
        nib_cout_s  = bin_sum_s[4];
        if (dec_q && is_sub_s) begin
            if (dec_diff_s[4]) begin
                nib_digit_s = dec_diff_s[3:0] + 4'd10;
                nib_cout_s  = 1'b0;
            end else begin
                nib_digit_s = dec_diff_s[3:0];
                nib_cout_s  = 1'b1;
            end
        end else if (dec_q && (op_q == OP_ADC)) begin
            if (bin_sum_s > 5'd9) begin
                nib_digit_s = dec_adj_s;
                nib_cout_s  = 1'b1;
            end else begin
                nib_digit_s = bin_sum_s[3:0];
            end
        end else begin
            nib_digit_s = bin_sum_s[3:0];
        end
    end

    // Single-cycle result and carry for the non-arithmetic operations.
    always_comb begin
        logic_res_s = lhs_q;
        logic_c_s   = cin_q;
        case (op_q)
            OP_PASSR: logic_res_s = rhs_q;
            OP_AND:   logic_res_s = lhs_q & rhs_q;
            OP_OR:    logic_res_s = lhs_q | rhs_q;
            OP_XOR:   logic_res_s = lhs_q ^ rhs_q;
            OP_ROL: begin
                logic_res_s = {lhs_q[WIDTH-2:0], cin_q};
                logic_c_s   = lhs_q[WIDTH-1];
            end
            OP_ROR: begin
                logic_res_s = {cin_q, lhs_q[WIDTH-1:1]};
                logic_c_s   = lhs_q[0];
            end
            default: begin
                logic_res_s = lhs_q;
                logic_c_s   = cin_q;
            end
        endcase
    end

    // Handshake FSM, operand capture, nibble sequencing and flag update.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        op_d     = op_q;
        dec_d    = dec_q;
        fen_d    = fen_q;
        lhs_d    = lhs_q;
        rhs_d    = rhs_q;
        acc_d    = acc_q;
        cin_d    = cin_q;
        vin_d    = vin_q;
        nin_d    = nin_q;
        zin_d    = zin_q;
        c_d      = c_q;
        result_d = result_q;
        flag_c_d = flag_c_q;
        flag_v_d = flag_v_q;
        flag_n_d = flag_n_q;
        flag_z_d = flag_z_q;
        finish_s = 1'b0;
        fin_res_s = logic_res_s;
        fin_c_s   = logic_c_s;
        fin_v_s   = vin_q;
        arith_res_s = acc_q;
        arith_res_s[base_s +: 4] = nib_digit_s;
        rhs_eff_msb_s = is_sub_s ? ~rhs_q[WIDTH-1] : rhs_q[WIDTH-1];
        accept_s = I_start && (state_q != S_RUN);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept_s) begin
                    state_d = S_RUN;
                    idx_d   = '0;
                    op_d    = I_op;
                    dec_d   = I_decimal;
                    fen_d   = I_flags_en;
                    lhs_d   = I_lhs;
                    rhs_d   = I_rhs;
                    acc_d   = '0;
                    cin_d   = I_carry;
                    vin_d   = I_overflow;
                    nin_d   = I_sign;
                    zin_d   = I_zero;
                    c_d     = I_carry;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (is_arith_s) begin
                    acc_d = arith_res_s;
                    c_d   = nib_cout_s;
                    idx_d = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        finish_s  = 1'b1;
                        fin_res_s = arith_res_s;
                        fin_c_s   = nib_cout_s;
                        fin_v_s   = dec_q ? vin_q :
                                    ((lhs_q[WIDTH-1] == rhs_eff_msb_s) &&
                                     (arith_res_s[WIDTH-1] != lhs_q[WIDTH-1]));
                    end else begin
                        finish_s = 1'b0;
                    end
                end else begin
                    finish_s = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Disabled flags pass the operand-time input value through.
        if (finish_s) begin
            state_d  = S_DONE;
            result_d = fin_res_s;
            flag_c_d = fen_q[3] ? fin_c_s : cin_q;
            flag_z_d = fen_q[2] ? (fin_res_s == '0) : zin_q;
            flag_v_d = fen_q[1] ? fin_v_s : vin_q;
            flag_n_d = fen_q[0] ? fin_res_s[WIDTH-1] : nin_q;
        end else begin
            result_d = result_q;
        end

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge I_clock) begin
        if (I_reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            op_q     <= 4'd0;
            dec_q    <= 1'b0;
            fen_q    <= 4'd0;
            lhs_q    <= '0;
            rhs_q    <= '0;
            acc_q    <= '0;
            cin_q    <= 1'b0;
            vin_q    <= 1'b0;
            nin_q    <= 1'b0;
            zin_q    <= 1'b0;
            c_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            flag_c_q <= 1'b0;
            flag_v_q <= 1'b0;
            flag_n_q <= 1'b0;
            flag_z_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            op_q     <= op_d;
            dec_q    <= dec_d;
            fen_q    <= fen_d;
            lhs_q    <= lhs_d;
            rhs_q    <= rhs_d;
            acc_q    <= acc_d;
            cin_q    <= cin_d;
            vin_q    <= vin_d;
            nin_q    <= nin_d;
            zin_q    <= zin_d;
            c_q      <= c_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            flag_c_q <= flag_c_d;
            flag_v_q <= flag_v_d;
            flag_n_q <= flag_n_d;
            flag_z_q <= flag_z_d;
        end
    end

    assign O_busy     = busy_q;
    assign O_done     = done_q;
    assign O_result   = result_q;
    assign O_carry    = flag_c_q;
    assign O_overflow = flag_v_q;
    assign O_sign     = flag_n_q;
    assign O_zero     = flag_z_q;

endmodule

// File: doc/core_alu_wide.md
# core_alu_wide

Parametrised, multi-cycle successor to the 8-bit combinational core ALU. Operands are WIDTH bits wide; add and subtract run digit-serially, one 4-bit nibble per clock, with optional packed-BCD (decimal) correction. Logic, pass and rotate operations complete in one clock. Results and C/Z/V/N flags are registered and presented under a start/busy/done handshake to the sequencer that owns the register file.

## Interface
- WIDTH, 16: operand and result width in bits. Must be a multiple of 4 and at least 8.
- I_clock  in  1  system clock; all state changes on the rising edge.
- I_reset  in  1  synchronous, active-high reset.
- I_start  in  1  request; sampled only when O_busy=0.
- I_op  in  4  operation: 0 PASSL, 1 PASSR, 2 ADC, 3 SBC, 4 AND, 5 OR, 6 XOR, 7 ROL, 8 ROR. Codes 9-15 behave as PASSL.
- I_decimal  in  1  BCD mode for ADC/SBC; ignored by other operations.
- I_flags_en  in  4  per-flag update enable {C,Z,V,N} = bits {3,2,1,0}.
- I_lhs, I_rhs  in  WIDTH  operands.
- I_carry, I_overflow, I_sign, I_zero  in  1 each  incoming flag values.
- O_busy  out  1  operation in progress.
- O_done  out  1  one-cycle pulse: result and flags are valid.
- O_result  out  WIDTH  registered result.
- O_carry, O_overflow, O_sign, O_zero  out  1 each  registered flags.

## Operation
- The block has three states: IDLE, RUN and DONE. A start is accepted in IDLE or DONE when I_start=1. On acceptance, all inputs are latched and the state moves to RUN with the nibble index at 0.
- A start asserted while in RUN is ignored and is not queued.
- For single-cycle operations, RUN computes the result on its first edge and moves to DONE. DONE lasts one cycle and then falls to IDLE unless a new start is accepted in that cycle.
- ADC, binary mode: nibble i is computed as s = lhs[i] + rhs[i] + c, with a 5-bit sum. Bits [3:0] go to the result and bit 4 becomes the next c. The initial c is the latched I_carry.
- ADC, decimal mode: if s > 9, then s = s + 6 and carry-out = 1; otherwise carry-out = s[4]. The result nibble is s[3:0]. Invalid digits (A-F) receive the same rule with no error indication.
- SBC, binary mode: identical to ADC with rhs bitwise inverted.
- SBC, decimal mode: d = lhs[i] - rhs[i] - (1 - c). If d < 0, then d = d + 10 and c = 0; otherwise c = 1. The result nibble is d[3:0].
- Arithmetic finishes after WIDTH/4 nibble steps and then enters DONE.
- AND, OR and XOR are bitwise on the full width. PASSL returns lhs and PASSR returns rhs.
- ROL: {C, result} = {lhs, C_in}. ROR: {result, C} = {C_in, lhs}.
- Flag outputs are set as follows, but only where the matching I_flags_en bit is 1. Any flag whose enable bit is 0 takes the latched input value.
  - C: final carry for ADC/SBC, the shifted-out bit for ROL/ROR, and the latched I_carry for all other operations.
  - Z: result == 0, for all operations.
  - N: result[WIDTH-1], for all operations.
  - V, binary ADC/SBC: (lhs[W-1] == rhs'[W-1]) && (result[W-1] != lhs[W-1]), where rhs' is the inverted rhs for SBC. For every other operation, and in decimal mode, V takes the latched I_overflow.
- O_result and the flags update only on entry to DONE. They hold their value until the next operation's DONE. Intermediate nibbles are not visible on O_result.

## Timing
- Reset values: state IDLE; O_busy=0, O_done=0, O_result=0, O_carry=0, O_overflow=0, O_sign=0, O_zero=0.
- Latency L is counted from the accepting edge k. L = WIDTH/4 for ADC/SBC and L = 1 for all other operations.
- O_busy=1 from after edge k through edge k+L-1.
- O_done=1 for exactly the cycle after edge k+L. O_busy=0 in that same cycle.
- Back-to-back operation: a start accepted in the DONE cycle produces the next O_done at L cycles after that edge, with no idle gap.
- Reset during RUN or DONE aborts the operation at the next edge. All outputs return to their reset values and no O_done is generated.
- If I_reset and I_start are asserted together, reset wins.
- Inputs are don't-care after acceptance. Changing them while O_busy=1 does not affect the result.

## Test plan
- Binary ADC, WIDTH=16: 0x7FFF + 0x0001 with C=0 and all flags enabled -> 0x8000, V=1, N=1, C=0, Z=0. O_done is asserted 4 cycles after start and O_busy is high for exactly 4 cycles.
- Decimal ADC: 0x0999 + 0x0001 with C=0 -> 0x1000, C=0. Then 0x9999 + 0x0001 -> 0x0000, C=1, Z=1. V is held at the input value in both cases.
- Subtraction: decimal SBC 0x1000 - 0x0001 with C=1 -> 0x0999, C=1. Binary SBC 0x0000 - 0x0001 with C=1 -> 0xFFFF, C=0, N=1.
- Single-cycle operations: ROR 0x0001 with C=1 -> 0x8000, C=1, O_done 1 cycle after start. AND 0xF0F0 & 0x0F0F -> 0x0000, Z=1, C unchanged.
- Handshake: a start pulse during RUN is ignored. A start issued in the DONE cycle is accepted back-to-back. With I_flags_en=0, all flags equal the latched inputs and O_result still updates.
- Reset: asserting reset in the 2nd RUN cycle of an ADC produces no O_done, all outputs are 0 on the next cycle, and a fresh start afterwards completes normally.
